// File: rtl/regfile_wb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
package regfile_wb_pkg;

  localparam int unsigned RF_ADDR_W  = 5;
  localparam int unsigned RF_DATA_W  = 32;
  localparam int unsigned GRANT_ID_W = 3;

  typedef enum logic [0:0] {
    WB_ARB,
    WB_LOCKED
  } wb_state_e;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester handshake and register-file write-port bundle for regfile_wb_arbiter.
// Stats ports exist only when WB_ARB_STATS_EN is defined.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
);
  import regfile_wb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        req_lock_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic                      wb_stall_i;
  logic                      RegWrite_o;
  logic [ADDR_W-1:0]         RDaddr_o;
  logic [DATA_W-1:0]         RDdata_o;
  logic [GRANT_ID_W-1:0]     grant_id_o;
  logic                      lock_active_o;
`ifdef WB_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     grant_cnt_o;
  logic [15:0]               conflict_cnt_o;
`endif

  modport master (
    output req_valid_i, req_lock_i, req_addr_i, req_data_i, wb_stall_i,
    input  req_ready_o, RegWrite_o, RDaddr_o, RDdata_o, grant_id_o, lock_active_o
`ifdef WB_ARB_STATS_EN
    , input grant_cnt_o, conflict_cnt_o
`endif
  );

  modport slave (
    input  req_valid_i, req_lock_i, req_addr_i, req_data_i, wb_stall_i,
    output req_ready_o, RegWrite_o, RDaddr_o, RDdata_o, grant_id_o, lock_active_o
`ifdef WB_ARB_STATS_EN
    , output grant_cnt_o, conflict_cnt_o
`endif
  );

endinterface

// File: rtl/rr_picker.sv
// Rotate-priority picker: first set request at or above ptr_i (with wrap), one-hot plus index.
module rr_picker #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  localparam logic [PTR_W:0] NumReq = (PTR_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [PTR_W:0]     sum;

  always_comb begin
    // rot[o] is request (ptr_i + o) mod NUM_REQ
    rot   = NUM_REQ'({req_i, req_i} >> ptr_i);
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      if (!any_o && rot[o]) begin
        any_o = 1'b1;
        sum   = (PTR_W+1)'(o) + {1'b0, ptr_i};
        if (sum >= NumReq) begin
          sum = sum - NumReq;
        end
        idx_o = sum[PTR_W-1:0];
      end
    end
    if (any_o) begin
      gnt_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_o;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter with burst lock feeding a registered register-file write port.
// Define WB_ARB_STATS_EN to add saturating grant/conflict counters.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned LOCK_MAX = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned    PTR_W    = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LastIdx = PTR_W'(NUM_REQ - 1);
  localparam logic [4:0]     LockMaxW = 5'(LOCK_MAX);
  localparam bit             LockEn   = (LOCK_MAX > 1);

  wb_state_e             state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [3:0]            lock_cnt_q, lock_cnt_d;
  logic [4:0]            cnt_inc;

  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [GRANT_ID_W-1:0] gid_q, gid_d;

  logic [NUM_REQ-1:0]    owner_oh, cand, pick_gnt, ready;
  logic [PTR_W-1:0]      pick_idx;
  logic                  pick_any, xfer;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_data;
  logic                  sel_lock;

  assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

  // While locked, everyone but the owner is masked out, even if the owner is idle.
  always_comb begin
    cand = bus.req_valid_i;
    if (state_q == WB_LOCKED) begin
      cand = bus.req_valid_i & owner_oh;
    end
  end

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_picker (
    .req_i(cand),
    .ptr_i(rr_ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  always_comb begin
    ready = pick_gnt;
    xfer  = pick_any;
    if (bus.wb_stall_i || rst_n) begin
      ready = '0;
      xfer  = 1'b0;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_addr = bus.req_addr_i[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data_i[i*DATA_W +: DATA_W];
        sel_lock = bus.req_lock_i[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    gid_d      = gid_q;
    cnt_inc    = {1'b0, lock_cnt_q} + 5'd1;
    if (xfer) begin
      // x0 writes are consumed but never reach the register file
      we_d     = (sel_addr != '0);
      addr_d   = sel_addr;
      data_d   = sel_data;
      gid_d    = GRANT_ID_W'(pick_idx);
      rr_ptr_d = (pick_idx == LastIdx) ? '0 : pick_idx + PTR_W'(1);
      case (state_q)
        WB_ARB: begin
          if (sel_lock && LockEn) begin
            state_d    = WB_LOCKED;
            owner_d    = pick_idx;
            lock_cnt_d = 4'd1;
          end
        end
        WB_LOCKED: begin
          lock_cnt_d = cnt_inc[3:0];
          if (!sel_lock || (cnt_inc >= LockMaxW)) begin
            state_d    = WB_ARB;
            lock_cnt_d = '0;
          end
        end
        default: state_d = WB_ARB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= WB_ARB;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      gid_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      gid_q      <= gid_d;
    end
  end

  assign bus.req_ready_o   = ready;
  assign bus.RegWrite_o    = we_q;
  assign bus.RDaddr_o      = addr_q;
  assign bus.RDdata_o      = data_q;
  assign bus.grant_id_o    = gid_q;
  assign bus.lock_active_o = (state_q == WB_LOCKED);

`ifdef WB_ARB_STATS_EN
  logic [15:0] gcnt_q [NUM_REQ];
  logic [15:0] gcnt_d [NUM_REQ];
  logic [15:0] ccnt_q, ccnt_d;
  logic        conflict;

  // Contention: several sources valid at once, or a non-owner stuck behind a lock.
  always_comb begin
    conflict = ($countones(bus.req_valid_i) > 1) ||
               ((state_q == WB_LOCKED) && (|(bus.req_valid_i & ~owner_oh)));
    ccnt_d   = ccnt_q;
    if (conflict && (ccnt_q != 16'hFFFF)) begin
      ccnt_d = ccnt_q + 16'd1;
    end
    gcnt_d = gcnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer && pick_gnt[i] && (gcnt_q[i] != 16'hFFFF)) begin
        gcnt_d[i] = gcnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ccnt_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        gcnt_q[i] <= '0;
      end
    end else begin
      ccnt_q <= ccnt_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        gcnt_q[i] <= gcnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_gcnt
    assign bus.grant_cnt_o[g*16 +: 16] = gcnt_q[g];
  end
  assign bus.conflict_cnt_o = ccnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-cycle reference model plus literal order/write checks.
module tb_regfile_wb_arbiter;

  localparam int N    = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int LMAX = 4;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;

  regfile_wb_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_wb_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .LOCK_MAX(LMAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  item_t       rq [N][$];
  logic [N-1:0] xfer_seen = '0;
  int          glog[$];
  int          wlog_a[$];
  int          wlog_d[$];
  logic [DW-1:0] rf [32];
  int          lock_cyc = 0;
  int          stall_ready = 0;
  int          stall_pulse = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: arbitration state as plain integers.
  int   m_ptr, m_owner, m_cnt, m_addr, m_data, m_gid, m_k;
  bit   m_locked, m_we;
  logic [N-1:0] m_ready;
`ifdef WB_ARB_STATS_EN
  int   m_gc[N];
  int   m_cc;
`endif

  always @(negedge clk) begin : cmp
    if (rst_n) begin
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
      m_we = 0; m_addr = 0; m_data = 0; m_gid = 0;
      m_ready = '0; m_k = -1;
`ifdef WB_ARB_STATS_EN
      for (int i = 0; i < N; i++) m_gc[i] = 0;
      m_cc = 0;
`endif
    end else begin
      m_k = -1;
      if (!bus.wb_stall_i) begin
        for (int o = 0; o < N; o++) begin
          int r;
          r = (m_ptr + o) % N;
          if (m_k < 0 && bus.req_valid_i[r] && (!m_locked || r == m_owner)) m_k = r;
        end
      end
      m_ready = '0;
      if (m_k >= 0) m_ready[m_k] = 1'b1;
    end

    chk("ready",       64'(bus.req_ready_o),   64'(m_ready));
    chk("regwrite",    64'(bus.RegWrite_o),    64'(m_we));
    chk("rdaddr",      64'(bus.RDaddr_o),      64'(m_addr));
    chk("rddata",      64'(bus.RDdata_o),      64'(m_data));
    chk("grant_id",    64'(bus.grant_id_o),    64'(m_gid));
    chk("lock_active", 64'(bus.lock_active_o), 64'(m_locked));
`ifdef WB_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", 64'(bus.grant_cnt_o[i*16 +: 16]), 64'(m_gc[i]));
    chk("conflict_cnt", 64'(bus.conflict_cnt_o), 64'(m_cc));
`endif

    if (!rst_n) begin
`ifdef WB_ARB_STATS_EN
      if ($countones(bus.req_valid_i) > 1 ||
          (m_locked && ((bus.req_valid_i & ~(N'(1) << m_owner)) != '0))) begin
        if (m_cc < 65535) m_cc++;
      end
      if (m_k >= 0 && m_gc[m_k] < 65535) m_gc[m_k]++;
`endif
      m_we = 0;
      if (m_k >= 0) begin
        m_addr = int'(bus.req_addr_i[m_k*AW +: AW]);
        m_data = int'(bus.req_data_i[m_k*DW +: DW]);
        m_we   = (m_addr != 0);
        m_gid  = m_k;
        m_ptr  = (m_k + 1) % N;
        if (!m_locked) begin
          if (bus.req_lock_i[m_k] && LMAX > 1) begin
            m_locked = 1; m_owner = m_k; m_cnt = 1;
          end
        end else begin
          m_cnt++;
          if (!bus.req_lock_i[m_k] || m_cnt >= LMAX) begin
            m_locked = 0; m_cnt = 0;
          end
        end
      end
    end

    // Observation logs for the literal checks.
    for (int i = 0; i < N; i++) if (bus.req_ready_o[i]) glog.push_back(i);
    if (bus.RegWrite_o) begin
      wlog_a.push_back(int'(bus.RDaddr_o));
      wlog_d.push_back(int'(bus.RDdata_o));
      rf[bus.RDaddr_o] = bus.RDdata_o;
    end
    if (bus.lock_active_o) lock_cyc++;
    if (bus.wb_stall_i && (bus.req_ready_o != '0)) stall_ready++;
    if (bus.wb_stall_i && bus.RegWrite_o) stall_pulse++;
    xfer_seen = bus.req_valid_i & bus.req_ready_o;
  end

  task automatic push(input int r, input int a, input int d, input bit l);
    item_t it;
    it.a = AW'(a);
    it.d = DW'(d);
    it.l = l;
    rq[r].push_back(it);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        bus.req_valid_i[i]           = 1'b1;
        bus.req_lock_i[i]            = rq[i][0].l;
        bus.req_addr_i[i*AW +: AW]   = rq[i][0].a;
        bus.req_data_i[i*DW +: DW]   = rq[i][0].d;
      end else begin
        bus.req_valid_i[i]           = 1'b0;
        bus.req_lock_i[i]            = 1'b0;
        bus.req_addr_i[i*AW +: AW]   = '0;
        bus.req_data_i[i*DW +: DW]   = '0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (xfer_seen[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    drive();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    int c;
    c = 0;
    while (!all_empty() && c < 60) begin
      step();
      c++;
    end
    chk("drain", 64'(all_empty()), 64'd1);
    repeat (2) step();
  endtask

  task automatic clear_logs();
    glog.delete();
    wlog_a.delete();
    wlog_d.delete();
    lock_cyc = 0;
  endtask

  task automatic check_glog(input string nm, input int e[$]);
    chk({nm, "_len"}, 64'(glog.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < glog.size(); i++) chk(nm, 64'(glog[i]), 64'(e[i]));
  endtask

  task automatic check_wlog(input string nm, input int ea[$], input int ed[$]);
    chk({nm, "_len"}, 64'(wlog_a.size()), 64'(ea.size()));
    for (int i = 0; i < ea.size() && i < wlog_a.size(); i++) begin
      chk({nm, "_addr"}, 64'(wlog_a[i]), 64'(ea[i]));
      chk({nm, "_data"}, 64'(wlog_d[i]), 64'(ed[i]));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst_n = 1'b1;
    bus.wb_stall_i = 1'b0;
    drive();

    // Round robin, loaded while still in reset so ready must stay low until release.
    push(0, 1, 10, 0); push(0, 1, 11, 0);
    push(1, 2, 20, 0); push(1, 2, 21, 0);
    push(2, 3, 30, 0); push(2, 3, 31, 0);
    drive();
    repeat (3) step();
    chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_regwrite", 64'(bus.RegWrite_o), 64'd0);
    chk("rst_lock", 64'(bus.lock_active_o), 64'd0);
    clear_logs();
    rst_n = 1'b0;
    drain();
    check_glog("t1_order", '{0, 1, 2, 0, 1, 2});
    check_wlog("t1_writes", '{1, 2, 3, 1, 2, 3}, '{10, 20, 30, 11, 21, 31});
    chk("t1_rf1", 64'(rf[1]), 64'd11);
    chk("t1_rf3", 64'(rf[3]), 64'd31);

    // Burst lock with forced release after LOCK_MAX transfers.
    clear_logs();
    for (int i = 0; i < 6; i++) push(1, 5 + i, 100 + i, (i != 5));
    push(2, 4, 200, 0);
    drive();
    drain();
    check_glog("t2_order", '{1, 1, 1, 1, 2, 1, 1});
    chk("t2_lock_cycles", 64'(lock_cyc), 64'd4);
    chk("t2_rf4", 64'(rf[4]), 64'd200);

    // x0 write: accepted and rotates, but no write strobe.
    clear_logs();
    push(0, 0, 'hDEAD, 0);
    drive();
    drain();
    check_glog("t3_x0_grant", '{0});
    chk("t3_x0_nowrite", 64'(wlog_a.size()), 64'd0);
    chk("t3_rf0", 64'(rf[0]), 64'd0);
    clear_logs();
    push(0, 7, 'h70, 0);
    push(1, 8, 'h80, 0);
    drive();
    drain();
    check_glog("t3_rotate", '{1, 0});
    check_wlog("t3_writes", '{8, 7}, '{'h80, 'h70});

    // Stall for three cycles right after a transfer.
    clear_logs();
    push(0, 11, 'hB0, 0);
    push(1, 12, 'hC0, 0);
    push(2, 13, 'hD0, 0);
    drive();
    step();
    bus.wb_stall_i = 1'b1;
    repeat (3) step();
    bus.wb_stall_i = 1'b0;
    drain();
    chk("t4_stall_ready", 64'(stall_ready), 64'd0);
    chk("t4_stall_pulse", 64'(stall_pulse), 64'd1);
    check_glog("t4_order", '{1, 2, 0});
    check_wlog("t4_writes", '{12, 13, 11}, '{'hC0, 'hD0, 'hB0});

    // Reset during a locked burst with an output pulse pending.
    clear_logs();
    push(2, 20, 'h200, 1); push(2, 21, 'h201, 1);
    push(2, 22, 'h202, 1); push(2, 23, 'h203, 0);
    push(0, 30, 'h300, 0);
    drive();
    step();
    step();
    check_glog("t5_pre", '{2, 2});
    check_wlog("t5_pre_writes", '{20}, '{'h200});
    rst_n = 1'b1;
    #1;
    chk("t5_rst_regwrite", 64'(bus.RegWrite_o), 64'd0);
    chk("t5_rst_addr", 64'(bus.RDaddr_o), 64'd0);
    chk("t5_rst_data", 64'(bus.RDdata_o), 64'd0);
    chk("t5_rst_gid", 64'(bus.grant_id_o), 64'd0);
    chk("t5_rst_lock", 64'(bus.lock_active_o), 64'd0);
    chk("t5_rst_ready", 64'(bus.req_ready_o), 64'd0);
    clear_logs();
    step();
    rst_n = 1'b0;
    drain();
    check_glog("t5_post", '{0, 2, 2});
    check_wlog("t5_post_writes", '{30, 22, 23}, '{'h300, 'h202, 'h203});
    chk("t5_squashed", 64'(rf[21]), 64'd0);

    // Same address back to back: later grant wins.
    clear_logs();
    push(0, 15, 'hA, 0);
    push(1, 15, 'hB, 0);
    drive();
    drain();
    check_glog("t6_order", '{0, 1});
    chk("t6_rf15", 64'(rf[15]), 64'hB);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
